// File: rtl/split_bus_pkg.sv
// Shared types and constants for the split-transaction bus arbiter: source IDs,
// the request field bundle and the bus widths.
package split_bus_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic {
        SRC_INSTR = 1'b0,
        SRC_DATA  = 1'b1
    } src_id_e;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } req_t;

    function automatic src_id_e otherSrc(input src_id_e s);
        return (s == SRC_DATA) ? SRC_INSTR : SRC_DATA;
    endfunction

    function automatic src_id_e toSrc(input logic b);
        return b ? SRC_DATA : SRC_INSTR;
    endfunction

endpackage

// File: rtl/split_route_fifo.sv
// Single-bit route FIFO holding the source ID of every outstanding read, with a
// synchronous active-high reset; depth is 2**POW entries.
module split_route_fifo #(
    parameter int POW = 3
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic push_i,
    input  logic pushId_i,
    input  logic pop_i,
    output logic headId_o,
    output logic full_o,
    output logic empty_o
);

    localparam int             DEPTH    = 1 << POW;
    localparam logic [POW:0]   FULL_CNT = (POW+1)'(DEPTH);

    logic [DEPTH-1:0] mem_q,   mem_d;
    logic [POW-1:0]   wrPtr_q, wrPtr_d;
    logic [POW-1:0]   rdPtr_q, rdPtr_d;
    logic [POW:0]     count_q, count_d;
    logic             doPush;
    logic             doPop;

    // Full and empty come from the registered count only, so a same-cycle pop
    // never frees room for a push.
    assign full_o   = (count_q == FULL_CNT);
    assign empty_o  = (count_q == '0);
    assign headId_o = mem_q[rdPtr_q];
    assign doPush   = push_i && !full_o;
    assign doPop    = pop_i && !empty_o;

    always_comb begin
        mem_d   = mem_q;
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (doPush) begin
            mem_d[wrPtr_q] = pushId_i;
            wrPtr_d        = wrPtr_q + 1'b1;
        end
        if (doPop) begin
            rdPtr_d = rdPtr_q + 1'b1;
        end
        case ({doPush, doPop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q   <= '0;
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/split_bus_arbiter2.sv
// Two-to-one split-transaction bus arbiter (instr + data onto one target port).
// Define SPLIT_ARB_RR_EN for round-robin; otherwise fixed priority, data over instr.
module split_bus_arbiter2
    import split_bus_pkg::*;
#(
    parameter int ROUTE_FIFO_POW = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              instr_req,
    input  logic              instr_we,
    input  logic [ADDR_W-1:0] instr_addr,
    input  logic [DATA_W-1:0] instr_wdata,
    input  logic [BE_W-1:0]   instr_be,
    output logic              instr_ack,
    output logic              instr_resp,
    output logic [DATA_W-1:0] instr_rdata,

    input  logic              data_req,
    input  logic              data_we,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    input  logic [BE_W-1:0]   data_be,
    output logic              data_ack,
    output logic              data_resp,
    output logic [DATA_W-1:0] data_rdata,

    output logic              target_req,
    output logic              target_we,
    output logic [ADDR_W-1:0] target_addr,
    output logic [DATA_W-1:0] target_wdata,
    output logic [BE_W-1:0]   target_be,
    input  logic              target_ack,
    input  logic              target_resp,
    input  logic [DATA_W-1:0] target_rdata,

    output logic              resp_err_o
);

    req_t    instrFields;
    req_t    dataFields;
    req_t    grantFields;
    logic    instrElig;
    logic    dataElig;
    logic    grantValid;
    src_id_e grantId;
    logic    xferAcc;
    logic    pushRead;
    logic    popResp;
    logic    spurious;

    logic    fifoFull;
    logic    fifoEmpty;
    logic    fifoHead;
    src_id_e headSrc;

    logic    lock_q,    lock_d;
    src_id_e lockId_q,  lockId_d;
    logic    respErr_q, respErr_d;
`ifdef SPLIT_ARB_RR_EN
    src_id_e prio_q,    prio_d;
`endif

    assign instrFields = '{we: instr_we, addr: instr_addr, wdata: instr_wdata, be: instr_be};
    assign dataFields  = '{we: data_we,  addr: data_addr,  wdata: data_wdata,  be: data_be};

    // A read may only be offered while the route FIFO still has room for its ID.
    assign instrElig = instr_req && (instr_we || !fifoFull);
    assign dataElig  = data_req  && (data_we  || !fifoFull);

    always_comb begin
        grantValid = 1'b0;
        grantId    = SRC_INSTR;
        if (lock_q) begin
            grantId    = lockId_q;
            grantValid = (lockId_q == SRC_DATA) ? data_req : instr_req;
        end else begin
`ifdef SPLIT_ARB_RR_EN
            if (prio_q == SRC_DATA) begin
                if (dataElig) begin
                    grantValid = 1'b1;
                    grantId    = SRC_DATA;
                end else if (instrElig) begin
                    grantValid = 1'b1;
                    grantId    = SRC_INSTR;
                end
            end else begin
                if (instrElig) begin
                    grantValid = 1'b1;
                    grantId    = SRC_INSTR;
                end else if (dataElig) begin
                    grantValid = 1'b1;
                    grantId    = SRC_DATA;
                end
            end
`else
            if (dataElig) begin
                grantValid = 1'b1;
                grantId    = SRC_DATA;
            end else if (instrElig) begin
                grantValid = 1'b1;
                grantId    = SRC_INSTR;
            end
`endif
        end
    end

    always_comb begin
        grantFields  = (grantId == SRC_DATA) ? dataFields : instrFields;
        target_req   = grantValid && !rst_i;
        target_we    = grantFields.we;
        target_addr  = grantFields.addr;
        target_wdata = grantFields.wdata;
        target_be    = grantFields.be;
        instr_ack    = target_req && target_ack && (grantId == SRC_INSTR);
        data_ack     = target_req && target_ack && (grantId == SRC_DATA);
    end

    assign xferAcc  = target_req && target_ack;
    assign pushRead = xferAcc && !grantFields.we;
    assign popResp  = target_resp && !fifoEmpty && !rst_i;
    assign spurious = target_resp && fifoEmpty;
    assign headSrc  = toSrc(fifoHead);

    always_comb begin
        instr_resp  = 1'b0;
        data_resp   = 1'b0;
        instr_rdata = '0;
        data_rdata  = '0;
        if (popResp) begin
            if (headSrc == SRC_DATA) begin
                data_resp  = 1'b1;
                data_rdata = target_rdata;
            end else begin
                instr_resp  = 1'b1;
                instr_rdata = target_rdata;
            end
        end
    end

    // A stalled request pins the grant so the host's held fields stay on the bus.
    always_comb begin
        lock_d    = 1'b0;
        lockId_d  = lockId_q;
        respErr_d = respErr_q || spurious;
        if (target_req && !target_ack) begin
            lock_d   = 1'b1;
            lockId_d = grantId;
        end
`ifdef SPLIT_ARB_RR_EN
        prio_d = prio_q;
        if (xferAcc) begin
            prio_d = otherSrc(grantId);
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_q    <= 1'b0;
            lockId_q  <= SRC_INSTR;
            respErr_q <= 1'b0;
        end else begin
            lock_q    <= lock_d;
            lockId_q  <= lockId_d;
            respErr_q <= respErr_d;
        end
    end

`ifdef SPLIT_ARB_RR_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prio_q <= SRC_INSTR;
        end else begin
            prio_q <= prio_d;
        end
    end
`endif

    assign resp_err_o = respErr_q;

    split_route_fifo #(
        .POW (ROUTE_FIFO_POW)
    ) u_routeFifo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .push_i   (pushRead),
        .pushId_i (grantId),
        .pop_i    (popResp),
        .headId_o (fifoHead),
        .full_o   (fifoFull),
        .empty_o  (fifoEmpty)
    );

endmodule

// File: tb/tb_split_bus_arbiter2.sv
// Self-checking bench for split_bus_arbiter2: directed scenarios plus randomized
// traffic compared against a queue-based reference model of the arbiter.
module tb_split_bus_arbiter2;

    localparam int POW   = 2;
    localparam int DEPTH = 1 << POW;

    logic        clk = 1'b0;
    logic        rst;
    logic        hReq   [2];
    logic        hWe    [2];
    logic [31:0] hAddr  [2];
    logic [31:0] hWdata [2];
    logic [3:0]  hBe    [2];
    logic        instrAck, instrResp, dataAck, dataResp;
    logic [31:0] instrRdata, dataRdata;
    logic        tReq, tWe;
    logic [31:0] tAddr, tWdata;
    logic [3:0]  tBe;
    logic        tAck, tResp;
    logic [31:0] tRdata;
    logic        respErr;

    int checkCount = 0;
    int errorCount = 0;

    // Reference model: outstanding read sources in issue order, lock owner, priority, sticky error.
    int routeQ[$];
    int lockPort = -1;
    int prio     = 0;
    bit mErr     = 1'b0;
    bit gotAck[2];
    bit pending[2];

    bit expData;
    bit prevData;
    logic [31:0] iAddr, dAddr;

    always #5 clk = ~clk;

    split_bus_arbiter2 #(
        .ROUTE_FIFO_POW (POW)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .instr_req    (hReq[0]),
        .instr_we     (hWe[0]),
        .instr_addr   (hAddr[0]),
        .instr_wdata  (hWdata[0]),
        .instr_be     (hBe[0]),
        .instr_ack    (instrAck),
        .instr_resp   (instrResp),
        .instr_rdata  (instrRdata),
        .data_req     (hReq[1]),
        .data_we      (hWe[1]),
        .data_addr    (hAddr[1]),
        .data_wdata   (hWdata[1]),
        .data_be      (hBe[1]),
        .data_ack     (dataAck),
        .data_resp    (dataResp),
        .data_rdata   (dataRdata),
        .target_req   (tReq),
        .target_we    (tWe),
        .target_addr  (tAddr),
        .target_wdata (tWdata),
        .target_be    (tBe),
        .target_ack   (tAck),
        .target_resp  (tResp),
        .target_rdata (tRdata),
        .resp_err_o   (respErr)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic setPort(input int p, input bit req, input bit we, input logic [31:0] addr);
        hReq[p]   = req;
        hWe[p]    = we;
        hAddr[p]  = addr;
        hWdata[p] = addr ^ 32'hA5A5_0000;
        hBe[p]    = 4'hF;
    endtask

    // Called just after a falling edge: compares DUT outputs with the model,
    // then advances the model across the rising edge.
    task automatic runCycle();
        int sel;
        int respPort;
        bit tr;
        bit full;
        bit el[2];
        #1;
        full = (routeQ.size() == DEPTH);
        for (int p = 0; p < 2; p++) el[p] = hReq[p] && (hWe[p] || !full);
        sel = -1;
        if (lockPort >= 0) begin
            sel = lockPort;
        end else begin
`ifdef SPLIT_ARB_RR_EN
            if (el[prio]) sel = prio;
            else if (el[1-prio]) sel = 1 - prio;
`else
            if (el[1]) sel = 1;
            else if (el[0]) sel = 0;
`endif
        end
        tr = 1'b0;
        if (sel >= 0 && !rst) tr = hReq[sel];
        checkOutput("target_req", tReq, tr);
        if (tr) begin
            checkOutput("target_we", tWe, hWe[sel]);
            checkOutput("target_addr", tAddr, hAddr[sel]);
            checkOutput("target_wdata", tWdata, hWdata[sel]);
            checkOutput("target_be", tBe, hBe[sel]);
        end
        gotAck[0] = tr && tAck && (sel == 0);
        gotAck[1] = tr && tAck && (sel == 1);
        checkOutput("instr_ack", instrAck, gotAck[0]);
        checkOutput("data_ack", dataAck, gotAck[1]);
        respPort = -1;
        if (!rst && tResp && routeQ.size() > 0) respPort = routeQ[0];
        checkOutput("instr_resp", instrResp, respPort == 0);
        checkOutput("data_resp", dataResp, respPort == 1);
        if (rst) begin
            checkOutput("instr_rdata_rst", instrRdata, 32'h0);
            checkOutput("data_rdata_rst", dataRdata, 32'h0);
        end else if (respPort == 0) begin
            checkOutput("instr_rdata", instrRdata, tRdata);
        end else if (respPort == 1) begin
            checkOutput("data_rdata", dataRdata, tRdata);
        end
        checkOutput("resp_err_o", respErr, mErr);
        @(posedge clk);
        if (rst) begin
            routeQ.delete();
            lockPort = -1;
            prio     = 0;
            mErr     = 1'b0;
        end else begin
            lockPort = (tr && !tAck) ? sel : -1;
            if (tResp) begin
                if (routeQ.size() > 0) void'(routeQ.pop_front());
                else mErr = 1'b1;
            end
            if (tr && tAck && !hWe[sel]) routeQ.push_back(sel);
            if (tr && tAck) prio = 1 - sel;
        end
        @(negedge clk);
    endtask

    task automatic idleAll();
        hReq[0] = 1'b0;
        hReq[1] = 1'b0;
        tAck    = 1'b0;
        tResp   = 1'b0;
        tRdata  = 32'h0;
    endtask

    task automatic drainResponses();
        idleAll();
        for (int k = 0; k < 2 * DEPTH + 4 && routeQ.size() > 0; k++) begin
            tResp  = 1'b1;
            tRdata = $urandom;
            runCycle();
        end
        tResp = 1'b0;
    endtask

    task automatic pulseReset();
        rst = 1'b1;
        runCycle();
        rst = 1'b0;
    endtask

    task automatic applyStimulus(input int cycles);
        pending[0] = 1'b0;
        pending[1] = 1'b0;
        idleAll();
        for (int c = 0; c < cycles; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pending[p] && $urandom_range(0, 1) == 1) begin
                    pending[p] = 1'b1;
                    setPort(p, 1'b1, ($urandom_range(0, 1) == 1), $urandom);
                    hBe[p] = 4'($urandom);
                end
                hReq[p] = pending[p];
            end
            tAck   = ($urandom_range(0, 9) < 6);
            tResp  = (routeQ.size() > 0) && ($urandom_range(0, 9) < 4);
            tRdata = $urandom;
            runCycle();
            for (int p = 0; p < 2; p++) if (gotAck[p]) pending[p] = 1'b0;
        end
        drainResponses();
    endtask

    initial begin
        rst = 1'b1;
        setPort(0, 1'b0, 1'b0, 32'h0);
        setPort(1, 1'b0, 1'b0, 32'h0);
        idleAll();
        @(negedge clk);
        @(negedge clk);

        // Reset state with requests and a response present.
        setPort(0, 1'b1, 1'b0, 32'h40);
        tAck  = 1'b1;
        tResp = 1'b1;
        #1;
        checkOutput("rst_target_req", tReq, 1'b0);
        checkOutput("rst_instr_ack", instrAck, 1'b0);
        checkOutput("rst_instr_resp", instrResp, 1'b0);
        runCycle();
        rst = 1'b0;
        idleAll();
        #1;
        checkOutput("post_rst_err", respErr, 1'b0);
        runCycle();

        // Single read, response two cycles after acceptance.
        setPort(0, 1'b1, 1'b0, 32'h100);
        tAck = 1'b1;
        #1;
        checkOutput("single_addr", tAddr, 32'h100);
        checkOutput("single_ack", instrAck, 1'b1);
        runCycle();
        idleAll();
        runCycle();
        tResp  = 1'b1;
        tRdata = 32'hDEAD_BEEF;
        #1;
        checkOutput("single_resp", instrResp, 1'b1);
        checkOutput("single_rdata", instrRdata, 32'hDEAD_BEEF);
        checkOutput("single_data_resp", dataResp, 1'b0);
        runCycle();
        tResp = 1'b0;
        #1;
        checkOutput("single_resp_end", instrResp, 1'b0);
        runCycle();

        // Contention: both ports read every cycle, target always accepts.
        iAddr = 32'h1000;
        dAddr = 32'h2000;
        setPort(0, 1'b1, 1'b0, iAddr);
        setPort(1, 1'b1, 1'b0, dAddr);
        tAck = 1'b1;
        prevData = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tResp  = (i > 0);
            tRdata = 32'hC000_0000 + 32'(i);
            #1;
`ifdef SPLIT_ARB_RR_EN
            expData = (i == 0) ? (prio == 1) : !prevData;
`else
            expData = 1'b1;
`endif
            checkOutput("contention_grant", dataAck, expData);
            prevData = expData;
            runCycle();
            if (gotAck[0]) begin
                iAddr = iAddr + 32'h4;
                setPort(0, 1'b1, 1'b0, iAddr);
            end
            if (gotAck[1]) begin
                dAddr = dAddr + 32'h4;
                setPort(1, 1'b1, 1'b0, dAddr);
            end
        end
        drainResponses();

        // Lock: instr stalled three cycles while data rises in the second.
        setPort(0, 1'b1, 1'b0, 32'h200);
        tAck = 1'b0;
        #1;
        checkOutput("lock_c0_addr", tAddr, 32'h200);
        runCycle();
        setPort(1, 1'b1, 1'b0, 32'h300);
        for (int c = 1; c < 3; c++) begin
            #1;
            checkOutput("lock_hold_addr", tAddr, 32'h200);
            checkOutput("lock_hold_dack", dataAck, 1'b0);
            runCycle();
        end
        tAck = 1'b1;
        #1;
        checkOutput("lock_release_iack", instrAck, 1'b1);
        checkOutput("lock_release_dack", dataAck, 1'b0);
        runCycle();
        hReq[0] = 1'b0;
        #1;
        checkOutput("lock_next_dack", dataAck, 1'b1);
        checkOutput("lock_next_addr", tAddr, 32'h300);
        runCycle();
        drainResponses();

        // FIFO full: four reads fill it, the fifth waits, a write still passes.
        tAck = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            setPort(0, 1'b1, 1'b0, 32'h400 + 32'(k));
            #1;
            checkOutput("fill_ack", instrAck, 1'b1);
            runCycle();
        end
        setPort(0, 1'b1, 1'b0, 32'h404);
        #1;
        checkOutput("full_iack", instrAck, 1'b0);
        checkOutput("full_treq", tReq, 1'b0);
        runCycle();
        setPort(1, 1'b1, 1'b1, 32'h500);
        #1;
        checkOutput("full_write_ack", dataAck, 1'b1);
        checkOutput("full_write_iack", instrAck, 1'b0);
        runCycle();
        hReq[1] = 1'b0;
        tResp   = 1'b1;
        tRdata  = 32'h0000_0011;
        #1;
        checkOutput("full_pop_iack", instrAck, 1'b0);
        checkOutput("full_pop_resp", instrResp, 1'b1);
        runCycle();
        tResp = 1'b0;
        #1;
        checkOutput("full_fifth_ack", instrAck, 1'b1);
        runCycle();
        drainResponses();

        // Spurious response with nothing outstanding.
        tResp  = 1'b1;
        tRdata = 32'h1234_5678;
        #1;
        checkOutput("spur_iresp", instrResp, 1'b0);
        checkOutput("spur_dresp", dataResp, 1'b0);
        runCycle();
        tResp = 1'b0;
        #1;
        checkOutput("spur_err_set", respErr, 1'b1);
        for (int c = 0; c < 3; c++) runCycle();
        #1;
        checkOutput("spur_err_held", respErr, 1'b1);
        runCycle();
        pulseReset();

        // Reset with three reads outstanding.
        tAck = 1'b1;
        for (int k = 0; k < 3; k++) begin
            setPort(0, 1'b1, 1'b0, 32'h600 + 32'(k));
            runCycle();
        end
        rst   = 1'b1;
        tResp = 1'b1;
        #1;
        checkOutput("midrst_treq", tReq, 1'b0);
        checkOutput("midrst_iack", instrAck, 1'b0);
        checkOutput("midrst_iresp", instrResp, 1'b0);
        checkOutput("midrst_irdata", instrRdata, 32'h0);
        runCycle();
        rst = 1'b0;
        idleAll();
        #1;
        checkOutput("midrst_err_clear", respErr, 1'b0);
        runCycle();
        tResp  = 1'b1;
        tRdata = 32'hBAD0_0001;
        #1;
        checkOutput("midrst_late_iresp", instrResp, 1'b0);
        runCycle();
        tResp = 1'b0;
        #1;
        checkOutput("midrst_late_err", respErr, 1'b1);
        runCycle();
        pulseReset();

        // Randomized traffic against the reference model.
        applyStimulus(600);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
